uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling-free UART receiver (8 data bits, 1 stop bit)
//
// The serial line is synchronized into clk, then a small FSM times each
// bit with a down-counter loaded from the baud divider captured at the
// start bit. Bits are sampled mid-bit; a good byte is pushed to the rx FIFO
// with a single-cycle strobe.
//
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames (even parity bit
// between the 8th data bit and the stop bit). Without it the frame is 8N1
// and rx_parity_err is tied low.
//
// Ports
//   clk               : sole clock, rising edge
//   rst_n             : asynchronous active-low reset
//   uart_rxd          : asynchronous serial input, idles high
//   UART_rx_en        : receiver enable
//   UART_baudrate_div : clk cycles per bit (values below 4 are ignored)
//   UART_rx_fifo_full : rx FIFO full flag
//   rx_fifo_wr_en     : one-cycle FIFO write strobe
//   UART_rx_data      : last received byte (valid with rx_fifo_wr_en)
//   rx_busy           : high whenever the FSM is not IDLE
//   rx_frame_err      : one-cycle pulse on a low stop bit
//   rx_overrun        : one-cycle pulse when a good byte is dropped (FIFO full)
//   rx_parity_err     : one-cycle pulse on an even-parity mismatch
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rxd,
  input  logic        UART_rx_en,
  input  logic [31:0] UART_baudrate_div,
  input  logic        UART_rx_fifo_full,
  output logic        rx_fifo_wr_en,
  output logic [7:0]  UART_rx_data,
  output logic        rx_busy,
  output logic        rx_frame_err,
  output logic        rx_overrun,
  output logic        rx_parity_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_t      state_q, state_d;
  logic [31:0] div_q, div_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        wr_en_q, wr_en_d;
  logic        busy_q, busy_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        sample;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
`endif

  // Metastability synchronizer for the serial line; resets to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
    end
  end

  assign rxs    = sync_q[SYNC_STAGES-1];
  // A bit is sampled when the bit timer has run down to zero.
  assign sample = (cnt_q == 32'd0);

  // State, timing and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= 32'd0;
      cnt_q   <= 32'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state and next-output logic of the receive FSM.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (!UART_rx_en) begin
      // Disabling abandons any frame silently.
      state_d = IDLE;
      cnt_d   = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // Dividers below 4 cannot place a mid-bit sample; ignore the start.
          if (!rxs && (UART_baudrate_div >= 32'd4)) begin
            state_d = START;
            div_d   = UART_baudrate_div;
            cnt_d   = (UART_baudrate_div >> 1) - 32'd1;
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (sample) begin
            state_d = rxs ? IDLE : DATA;
            cnt_d   = div_q - 32'd1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        DATA: begin
          if (sample) begin
            shift_d = {rxs, shift_q[7:1]};
            cnt_d   = div_q - 32'd1;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              state_d = DATA;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample) begin
            par_d   = rxs;
            cnt_d   = div_q - 32'd1;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
`endif
        STOP: begin
          if (sample) begin
            if (!rxs) begin
              ferr_d  = 1'b1;
              state_d = WAIT_HIGH;
            end else begin
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_q != (^shift_q)) begin
                perr_d = 1'b1;
              end else
`endif
              if (UART_rx_fifo_full) begin
                ovr_d = 1'b1;
              end else begin
                wr_en_d = 1'b1;
                data_d  = shift_q;
              end
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        WAIT_HIGH: begin
          // Hold off until the line returns high so a broken frame cannot
          // be mistaken for a new start bit.
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_HIGH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  assign rx_fifo_wr_en = wr_en_q;
  assign UART_rx_data  = data_q;
  assign rx_busy       = busy_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule
